// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential fetch requests, tags each in-flight
// request with its PC, and buffers in-order responses in a small prefetch FIFO
// for the decoder. Redirects flush the FIFO and drop responses to stale requests.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH     = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int unsigned           FIFO_DEPTH_POW = 2  // must be >= 1
) (
    input  logic                  clk_in,
    input  logic                  reset,
    output logic                  mem_req_valid_out,
    input  logic                  mem_req_ready_in,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_out,
    input  logic                  mem_resp_valid_in,
    input  logic [31:0]           mem_resp_data_in,
    input  logic                  mem_resp_err_in,
    output logic                  instr_valid_out,
    input  logic                  instr_ready_in,
    output logic [31:0]           instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc_out,
    output logic                  instr_fault_out,
    input  logic                  redirect_valid_in,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_in
);
    localparam int unsigned Depth = 1 << FIFO_DEPTH_POW;
    localparam int unsigned CntW  = FIFO_DEPTH_POW + 1;
    localparam int unsigned PtrW  = FIFO_DEPTH_POW;

    localparam logic [CntW:0]         DepthExt = Depth[CntW:0];
    localparam logic [ADDR_WIDTH-1:0] PcStep   = {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [ADDR_WIDTH-1:0] PcReset  = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

    typedef enum logic [0:0] {StFetch, StHalt} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]       inflight_q, inflight_d;
    logic [CntW-1:0]       discard_q, discard_d;

    // PC tag per in-flight request; occupancy always equals inflight_q.
    logic [ADDR_WIDTH-1:0] tag_q [Depth];
    logic [PtrW-1:0]       tag_wr_q, tag_wr_d;
    logic [PtrW-1:0]       tag_rd_q, tag_rd_d;

    logic [31:0]           fifo_data_q  [Depth];
    logic [ADDR_WIDTH-1:0] fifo_pc_q    [Depth];
    logic                  fifo_fault_q [Depth];
    logic [PtrW-1:0]       fifo_wr_q, fifo_wr_d;
    logic [PtrW-1:0]       fifo_rd_q, fifo_rd_d;
    logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;

    logic [CntW:0] occupancy;
    logic          req_fire;
    logic          resp_keep;
    logic          fifo_push;
    logic          fifo_pop;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc_in[1:0];

    // Credit check: a request only issues if its response is guaranteed a FIFO slot.
    // Gating with reset keeps the request channel quiet while reset is held.
    assign occupancy         = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign mem_req_valid_out = reset && (state_q == StFetch) && (occupancy < DepthExt)
                               && !redirect_valid_in;
    assign mem_req_addr_out  = fetch_pc_q;
    assign req_fire          = mem_req_valid_out && mem_req_ready_in;

    // A response arriving alongside a redirect is stale by definition.
    assign resp_keep = mem_resp_valid_in && (discard_q == '0) && !redirect_valid_in;
    assign fifo_push = resp_keep;
    assign fifo_pop  = instr_valid_out && instr_ready_in && !redirect_valid_in;

    assign instr_valid_out = (fifo_cnt_q != '0);
    assign instr_out       = instr_valid_out ? fifo_data_q[fifo_rd_q]  : '0;
    assign instr_pc_out    = instr_valid_out ? fifo_pc_q[fifo_rd_q]    : '0;
    assign instr_fault_out = instr_valid_out ? fifo_fault_q[fifo_rd_q] : 1'b0;

    // Next-state for fetch PC, counters and pointers; redirect overrides last.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PcStep;
            tag_wr_d   = tag_wr_q + 1'b1;
        end

        if (req_fire && !mem_resp_valid_in) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!req_fire && mem_resp_valid_in) begin
            inflight_d = inflight_q - 1'b1;
        end

        if (mem_resp_valid_in) begin
            tag_rd_d = tag_rd_q + 1'b1;
            if (discard_q != '0) begin
                discard_d = discard_q - 1'b1;
            end
        end

        if (fifo_push) begin
            fifo_wr_d = fifo_wr_q + 1'b1;
        end
        if (fifo_pop) begin
            fifo_rd_d = fifo_rd_q + 1'b1;
        end
        if (fifo_push && !fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!fifo_push && fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end

        if (redirect_valid_in) begin
            fetch_pc_d = {redirect_pc_in[ADDR_WIDTH-1:2], 2'b00};
            discard_d  = inflight_d;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end
    end

    // Issue FSM: a kept faulting response stops issue until the next redirect.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (resp_keep && mem_resp_err_in) begin
                    state_d = StHalt;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
        if (redirect_valid_in) begin
            state_d = StFetch;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= StFetch;
            fetch_pc_q <= PcReset;
            inflight_q <= '0;
            discard_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Tag and FIFO storage; contents are only observed through valid entries.
    always_ff @(posedge clk_in) begin
        if (req_fire) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
        if (fifo_push) begin
            fifo_data_q[fifo_wr_q]  <= mem_resp_data_in;
            fifo_pc_q[fifo_wr_q]    <= tag_q[tag_rd_q];
            fifo_fault_q[fifo_wr_q] <= mem_resp_err_in;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural in-order memory with selectable
// latency, a delivery monitor, and hand-computed expected PCs and words.
module tb_fetch_unit;
    logic        clk_in = 1'b0;
    logic        reset;
    logic        mem_req_valid_out;
    logic        mem_req_ready_in;
    logic [63:0] mem_req_addr_out;
    logic        mem_resp_valid_in;
    logic [31:0] mem_resp_data_in;
    logic        mem_resp_err_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [63:0] instr_pc_out;
    logic        instr_fault_out;
    logic        redirect_valid_in;
    logic [63:0] redirect_pc_in;

    fetch_unit #(
        .ADDR_WIDTH     (64),
        .RESET_PC       (64'h0),
        .FIFO_DEPTH_POW (2)
    ) dut (
        .clk_in            (clk_in),
        .reset             (reset),
        .mem_req_valid_out (mem_req_valid_out),
        .mem_req_ready_in  (mem_req_ready_in),
        .mem_req_addr_out  (mem_req_addr_out),
        .mem_resp_valid_in (mem_resp_valid_in),
        .mem_resp_data_in  (mem_resp_data_in),
        .mem_resp_err_in   (mem_resp_err_in),
        .instr_valid_out   (instr_valid_out),
        .instr_ready_in    (instr_ready_in),
        .instr_out         (instr_out),
        .instr_pc_out      (instr_pc_out),
        .instr_fault_out   (instr_fault_out),
        .redirect_valid_in (redirect_valid_in),
        .redirect_pc_in    (redirect_pc_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] data;
        logic        fault;
    } deliv_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] due;
    } pend_t;

    int          n_cmp;
    int          n_err;
    logic [63:0] acc_q[$];
    deliv_t      del_q[$];
    pend_t       pend_q[$];
    int unsigned mem_lat;
    logic [63:0] err_addr;
    logic [31:0] cyc;
    logic        s_fire, s_resp, s_rst;
    logic [63:0] s_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_in);
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        acc_q.delete();
        del_q.delete();
    endtask

    task automatic wait_deliv(input int n, input string tag);
        for (int i = 0; i < 200 && del_q.size() < n; i++) tick();
        check_eq(tag, 64'(del_q.size() >= n), 64'd1);
    endtask

    // Memory model: word at address A is A[31:0] + 0x1000_0000.
    initial begin
        mem_resp_valid_in = 1'b0;
        mem_resp_data_in  = '0;
        mem_resp_err_in   = 1'b0;
        cyc               = '0;
        forever begin
            @(negedge clk_in);
            s_fire = mem_req_valid_out && mem_req_ready_in;
            s_resp = mem_resp_valid_in;
            s_rst  = reset;
            s_addr = mem_req_addr_out;
            @(posedge clk_in);
            #1;
            cyc = cyc + 1;
            if (!s_rst) begin
                pend_q.delete();
            end else begin
                if (s_resp && pend_q.size() > 0) void'(pend_q.pop_front());
                if (s_fire) pend_q.push_back({s_addr, cyc + mem_lat - 1});
            end
            if (s_rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                mem_resp_valid_in = 1'b1;
                mem_resp_data_in  = pend_q[0].addr[31:0] + 32'h1000_0000;
                mem_resp_err_in   = (pend_q[0].addr == err_addr);
            end else begin
                mem_resp_valid_in = 1'b0;
                mem_resp_data_in  = '0;
                mem_resp_err_in   = 1'b0;
            end
        end
    end

    // Log accepted requests and consumed instructions at the coming edge.
    initial begin
        deliv_t d;
        forever begin
            @(negedge clk_in);
            if (reset && mem_req_valid_out && mem_req_ready_in) acc_q.push_back(mem_req_addr_out);
            if (reset && instr_valid_out && instr_ready_in && !redirect_valid_in) begin
                d.pc    = instr_pc_out;
                d.data  = instr_out;
                d.fault = instr_fault_out;
                del_q.push_back(d);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp             = 0;
        n_err             = 0;
        reset             = 1'b1;
        mem_req_ready_in  = 1'b1;
        instr_ready_in    = 1'b1;
        redirect_valid_in = 1'b0;
        redirect_pc_in    = '0;
        mem_lat           = 1;
        err_addr          = 64'h1;

        // Reset state
        tick();
        reset = 1'b0;
        repeat (2) tick();
        at_neg();
        check_eq("rst_req_valid", 64'(mem_req_valid_out), 64'd0);
        check_eq("rst_req_addr", mem_req_addr_out, 64'h0);
        check_eq("rst_instr_valid", 64'(instr_valid_out), 64'd0);
        check_eq("rst_instr", 64'(instr_out), 64'd0);
        check_eq("rst_instr_pc", instr_pc_out, 64'd0);
        check_eq("rst_fault", 64'(instr_fault_out), 64'd0);

        // Streaming after release: first instruction two cycles after first request
        tick();
        reset = 1'b1;
        acc_q.delete();
        del_q.delete();
        at_neg();
        check_eq("c0_req_valid", 64'(mem_req_valid_out), 64'd1);
        check_eq("c0_req_addr", mem_req_addr_out, 64'h0);
        check_eq("c0_instr_valid", 64'(instr_valid_out), 64'd0);
        at_neg();
        check_eq("c1_instr_valid", 64'(instr_valid_out), 64'd0);
        at_neg();
        check_eq("c2_instr_valid", 64'(instr_valid_out), 64'd1);
        check_eq("c2_pc", instr_pc_out, 64'h0);
        check_eq("c2_instr", 64'(instr_out), 64'h1000_0000);
        at_neg();
        check_eq("c3_pc", instr_pc_out, 64'h4);
        at_neg();
        check_eq("c4_pc", instr_pc_out, 64'h8);
        at_neg();
        check_eq("c5_pc", instr_pc_out, 64'hC);
        check_eq("c5_instr", 64'(instr_out), 64'h1000_000C);

        // Decoder stall: FIFO fills with exactly four requests, then drains in order
        tick();
        instr_ready_in = 1'b0;
        apply_reset();
        repeat (10) tick();
        check_eq("stall_req_count", 64'(acc_q.size()), 64'd4);
        at_neg();
        check_eq("stall_req_valid", 64'(mem_req_valid_out), 64'd0);
        check_eq("stall_head_pc", instr_pc_out, 64'h0);
        tick();
        instr_ready_in = 1'b1;
        del_q.delete();
        wait_deliv(5, "drain_wait");
        check_eq("drain_pc0", del_q[0].pc, 64'h0);
        check_eq("drain_pc1", del_q[1].pc, 64'h4);
        check_eq("drain_pc3", del_q[3].pc, 64'hC);
        check_eq("drain_data3", 64'(del_q[3].data), 64'h1000_000C);
        check_eq("drain_pc4", del_q[4].pc, 64'h10);
        check_eq("resume_addr", acc_q[4], 64'h10);

        // Three requests in flight with 3-cycle memory, then redirect to 0x1000
        mem_lat = 3;
        apply_reset();
        repeat (3) tick();
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 64'h1000;
        del_q.delete();
        at_neg();
        check_eq("redir_req_masked", 64'(mem_req_valid_out), 64'd0);
        tick();
        redirect_valid_in = 1'b0;
        at_neg();
        check_eq("redir_addr", mem_req_addr_out, 64'h1000);
        check_eq("redir_req_valid", 64'(mem_req_valid_out), 64'd1);
        check_eq("redir_instr_valid", 64'(instr_valid_out), 64'd0);
        wait_deliv(2, "redir_wait");
        check_eq("redir_first_pc", del_q[0].pc, 64'h1000);
        check_eq("redir_first_data", 64'(del_q[0].data), 64'h1000_1000);
        check_eq("redir_second_pc", del_q[1].pc, 64'h1004);

        // Access fault on PC 0x8: delivered with fault, issue stops, redirect resumes
        mem_lat  = 1;
        err_addr = 64'h8;
        apply_reset();
        repeat (12) tick();
        check_eq("fault_req_count", 64'(acc_q.size()), 64'd4);
        check_eq("fault_deliv_count", 64'(del_q.size()), 64'd4);
        check_eq("fault_pc4_flag", 64'(del_q[1].fault), 64'd0);
        check_eq("fault_pc", del_q[2].pc, 64'h8);
        check_eq("fault_flag", 64'(del_q[2].fault), 64'd1);
        check_eq("fault_data", 64'(del_q[2].data), 64'h1000_0008);
        check_eq("after_fault_pc", del_q[3].pc, 64'hC);
        at_neg();
        check_eq("halt_req_valid", 64'(mem_req_valid_out), 64'd0);
        tick();
        err_addr          = 64'h1;
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 64'h200;
        del_q.delete();
        tick();
        redirect_valid_in = 1'b0;
        at_neg();
        check_eq("halt_exit_addr", mem_req_addr_out, 64'h200);
        check_eq("halt_exit_valid", 64'(mem_req_valid_out), 64'd1);
        wait_deliv(1, "halt_exit_wait");
        check_eq("halt_exit_pc", del_q[0].pc, 64'h200);

        // Misaligned redirect while responses are arriving
        tick();
        mem_lat = 2;
        repeat (4) tick();
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 64'h103;
        del_q.delete();
        at_neg();
        check_eq("align_req_masked", 64'(mem_req_valid_out), 64'd0);
        tick();
        redirect_valid_in = 1'b0;
        at_neg();
        check_eq("align_addr", mem_req_addr_out, 64'h100);
        check_eq("align_instr_valid", 64'(instr_valid_out), 64'd0);
        wait_deliv(2, "align_wait");
        check_eq("align_pc0", del_q[0].pc, 64'h100);
        check_eq("align_data0", 64'(del_q[0].data), 64'h1000_0100);
        check_eq("align_pc1", del_q[1].pc, 64'h104);

        // Fetch PC wraps past the top of the address space
        tick();
        mem_lat           = 1;
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 64'hFFFF_FFFF_FFFF_FFF8;
        del_q.delete();
        tick();
        redirect_valid_in = 1'b0;
        wait_deliv(4, "wrap_wait");
        check_eq("wrap_pc0", del_q[0].pc, 64'hFFFF_FFFF_FFFF_FFF8);
        check_eq("wrap_pc1", del_q[1].pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("wrap_data1", 64'(del_q[1].data), 64'h0FFF_FFFC);
        check_eq("wrap_pc2", del_q[2].pc, 64'h0);
        check_eq("wrap_pc3", del_q[3].pc, 64'h4);

        // Reset asserted mid-stream clears outputs at once
        at_neg();
        check_eq("mid_pre_valid", 64'(instr_valid_out), 64'd1);
        tick();
        reset = 1'b0;
        #1;
        check_eq("mid_rst_instr_valid", 64'(instr_valid_out), 64'd0);
        check_eq("mid_rst_req_valid", 64'(mem_req_valid_out), 64'd0);
        check_eq("mid_rst_pc", instr_pc_out, 64'h0);
        check_eq("mid_rst_addr", mem_req_addr_out, 64'h0);
        repeat (2) tick();
        reset = 1'b1;
        acc_q.delete();
        del_q.delete();
        at_neg();
        check_eq("mid_restart_valid", 64'(mem_req_valid_out), 64'd1);
        check_eq("mid_restart_addr", mem_req_addr_out, 64'h0);
        wait_deliv(2, "mid_restart_wait");
        check_eq("mid_restart_pc0", del_q[0].pc, 64'h0);
        check_eq("mid_restart_pc1", del_q[1].pc, 64'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting between the program counter path and the instruction decoder. Issues sequential 32-bit fetch requests to instruction memory over a valid/ready request channel, accepts in-order responses, and buffers them in a small prefetch FIFO presented to the decoder with a valid/ready handshake. Supports pipeline redirects (branch/jump) that flush buffered and in-flight fetches.

## Interface
- ADDR_WIDTH, 64, fetch address / PC width
- RESET_PC, 64'h0, first fetch address after reset
- FIFO_DEPTH_POW, 2, prefetch FIFO depth = 1 << FIFO_DEPTH_POW entries

- clk_in  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- mem_req_valid_out  output  1  fetch request valid
- mem_req_ready_in  input  1  memory accepts request this cycle
- mem_req_addr_out  output  ADDR_WIDTH  fetch address, bits [1:0] always 0
- mem_resp_valid_in  input  1  response valid (in order, one per accepted request)
- mem_resp_data_in  input  32  instruction word
- mem_resp_err_in  input  1  access fault on this response
- instr_valid_out  output  1  FIFO head valid
- instr_ready_in  input  1  decoder consumes head this cycle
- instr_out  output  32  head instruction
- instr_pc_out  output  ADDR_WIDTH  PC of head instruction
- instr_fault_out  output  1  head entry carries access fault
- redirect_valid_in  input  1  flush and restart fetch
- redirect_pc_in  input  ADDR_WIDTH  new fetch PC; bits [1:0] treated as 0

## Operation
- Registers: fetch_pc, req_pc queue (PC tag per in-flight request), inflight count, discard count, FIFO (data, pc, fault), state.
- States: FETCH (issue enabled), HALT (issue disabled after fault). Reset -> FETCH.
- Credit rule: mem_req_valid_out = (state==FETCH) && (fifo_count + inflight < DEPTH) && !redirect_valid_in. Guarantees every response has a FIFO slot; no response backpressure exists.
- Request accepted (valid && ready): fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH), inflight += 1, PC tag pushed.
- Unaccepted request: address stable until accepted unless a redirect occurs; redirect may withdraw it.
- Response with discard==0: entry {data, tag PC, err} enqueued; inflight -= 1. If err: state -> HALT; entry still delivered with instr_fault_out=1.
- Response with discard>0: dropped; discard -= 1, inflight -= 1.
- Redirect: FIFO cleared, fetch_pc <= {redirect_pc_in[ADDR_WIDTH-1:2],2'b00}, state -> FETCH, discard <= inflight_next (includes request accepted same cycle, excludes response arriving same cycle, which is itself dropped). Decoder handshake in redirect cycle is ignored (entry discarded, not considered consumed).
- Simultaneous FIFO push and pop: count unchanged; push to empty FIFO appears at head next cycle.
- HALT: no new requests; outstanding responses still handled; exits only via redirect.

## Timing
- Reset (asynchronous assert, synchronous release): fetch_pc=RESET_PC, all outputs 0 except mem_req_valid_out, which goes 1 in first cycle after release (addr RESET_PC).
- Request issue: combinational from registered state; one request per cycle max.
- Response at edge M -> instr_valid_out high after edge M (visible cycle M+1). Zero-latency bypass forbidden.
- Redirect sampled at edge N -> instr_valid_out=0 and mem_req_addr_out = new PC in cycle N+1.
- Full throughput: with single-cycle memory and instr_ready_in=1, one instruction per cycle sustained.
- Counters width FIFO_DEPTH_POW+1; inflight never exceeds DEPTH.

## Test plan
- Reset release, mem always ready, 1-cycle response, decoder ready -> instructions at PC 0,4,8,12… one per cycle, first valid 2 cycles after first request.
- Decoder ready=0 for 10 cycles -> exactly 4 requests issued, FIFO full, mem_req_valid_out=0; ready=1 -> drains in order PC 0..12, fetch resumes at 16.
- 3 requests in flight (3-cycle memory), redirect to 0x1000 -> 3 stale responses dropped, next delivered instr has PC 0x1000.
- Response for PC 0x8 with err=1 -> delivered with instr_fault_out=1, no further requests; redirect to 0x200 resumes fetch at 0x200.
- Redirect to 0x103 -> fetch address 0x100; redirect coinciding with response and request acceptance -> both stale, discard count correct, no stale instr delivered.
- fetch_pc near 2^64-4 -> wraps to 0; reset asserted mid-stream -> outputs cleared immediately, restart at RESET_PC.
